bin2gray_stream: RTL and testbench

//   Streaming binary-to-Gray symbol encoder for the modulation datapath: maps

---
 rtl/bin2gray_stream.sv | 80 ++++++++
 tb/tb_bin2gray_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2gray_stream.sv
`default_nettype none
// ============================================================================
// Module   : bin2gray_stream
// Purpose  : Pipelined binary-to-Gray symbol encoder with valid/ready flow
//            control on both sides, one symbol per cycle, bubble collapsing.
// Revision : 1.0 - initial release
// ============================================================================
module bin2gray_stream #(
    parameter int  MODULATION_ORDER = 16,
    parameter int  PIPE_STAGES      = 2,
    localparam int W                = $clog2(MODULATION_ORDER)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_binary_code,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_gray_code,
    output logic         o_busy
);

    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] vld_d;
    logic [W-1:0]           data_q [PIPE_STAGES];
    logic [W-1:0]           data_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] w_adv;
    logic [W-1:0]           w_gray;
    logic                   w_accept;

    assign w_gray   = i_binary_code ^ (i_binary_code >> 1);
    assign o_ready  = w_adv[0] & rst_n;
    assign w_accept = i_valid & o_ready;

    // A stage may advance if it is empty or the stage after it advances,
    // so bubbles anywhere in the pipe are squeezed out.
    always_comb begin
        w_adv = '0;
        w_adv[PIPE_STAGES-1] = ~vld_q[PIPE_STAGES-1] | i_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            w_adv[k] = ~vld_q[k] | w_adv[k+1];
        end
    end

    always_comb begin
        vld_d     = '0;
        data_d[0] = w_gray;
        vld_d[0]  = w_accept;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            vld_d[k]  = vld_q[k-1];
            data_d[k] = data_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (w_adv[k]) begin
                    vld_q[k] <= vld_d[k];
                    // Data only moves with a real symbol; an empty output keeps its last code.
                    if (vld_d[k]) begin
                        data_q[k] <= data_d[k];
                    end
                end
            end
        end
    end

    assign o_valid     = vld_q[PIPE_STAGES-1];
    assign o_gray_code = data_q[PIPE_STAGES-1];
    assign o_busy      = |vld_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2gray_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2gray_stream
// Purpose  : Directed self-checking bench for bin2gray_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin2gray_stream;

    localparam int PS = 2;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_binary_code;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_gray_code;
    logic       o_busy;

    logic       rt_valid;
    logic       rt_ready;
    logic [1:0] d4;
    logic [5:0] d64;
    logic [7:0] d256;
    logic       or4, or64, or256;
    logic       ov4, ov64, ov256;
    logic       ob4, ob64, ob256;
    logic [1:0] og4;
    logic [5:0] og64;
    logic [7:0] og256;

    int errors;
    int checks;

    logic [3:0] out_q [$];
    logic [7:0] rec4 [$];
    logic [7:0] rec64 [$];
    logic [7:0] rec256 [$];
    logic [7:0] rt_in [$];

    logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    bin2gray_stream #(.MODULATION_ORDER(16), .PIPE_STAGES(PS)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_binary_code(i_binary_code), .o_valid(o_valid), .i_ready(i_ready),
        .o_gray_code(o_gray_code), .o_busy(o_busy)
    );

    bin2gray_stream #(.MODULATION_ORDER(4), .PIPE_STAGES(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_valid(rt_valid), .o_ready(or4),
        .i_binary_code(d4), .o_valid(ov4), .i_ready(rt_ready),
        .o_gray_code(og4), .o_busy(ob4)
    );

    bin2gray_stream #(.MODULATION_ORDER(64), .PIPE_STAGES(3)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .i_valid(rt_valid), .o_ready(or64),
        .i_binary_code(d64), .o_valid(ov64), .i_ready(rt_ready),
        .o_gray_code(og64), .o_busy(ob64)
    );

    bin2gray_stream #(.MODULATION_ORDER(256), .PIPE_STAGES(2)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .i_valid(rt_valid), .o_ready(or256),
        .i_binary_code(d256), .o_valid(ov256), .i_ready(rt_ready),
        .o_gray_code(og256), .o_busy(ob256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive-side Gray-to-binary converter for the round-trip test.
    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Handshake state is stable mid-cycle, so the falling edge sees what the next rising edge transfers.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) out_q.push_back(o_gray_code);
        if (rst_n && rt_ready) begin
            if (ov4)   rec4.push_back(g2b({6'b0, og4}));
            if (ov64)  rec64.push_back(g2b({2'b0, og64}));
            if (ov256) rec256.push_back(g2b(og256));
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        for (int n = 0; n < 2; n++) begin
            i_valid       = 1'($urandom_range(0, 1));
            i_ready       = 1'($urandom_range(0, 1));
            i_binary_code = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
        checks++; if (o_gray_code !== 4'd0) begin errors++; $display("FAIL reset_o_gray_code: got %0d expected 0", o_gray_code); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_o_ready: got %b expected 0", o_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_o_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_map;
        logic exp_v;
        rst_n = 1'b1; i_ready = 1'b1; i_valid = 1'b1; i_binary_code = 4'd0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL map_first_ready: got %b expected 1", o_ready); end
        for (int k = 1; k <= 16 + PS; k++) begin
            i_valid       = (k <= 16);
            i_binary_code = (k <= 16) ? 4'(k - 1) : 4'd0;
            @(posedge clk); #1;
            exp_v = (k >= PS) && (k < 16 + PS);
            checks++;
            if (o_valid !== exp_v) begin
                errors++; $display("FAIL map_valid_edge%0d: got %b expected %b", k, o_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (o_gray_code !== gray_tab[k-PS]) begin
                    errors++; $display("FAIL map_gray_b%0d: got %0d expected %0d", k - PS, o_gray_code, gray_tab[k-PS]);
                end
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int sent;
        int cyc;
        logic acc;
        logic [3:0] held;
        out_q.delete(); sent = 0; cyc = 0; held = '0;
        while (sent < 16 && cyc < 200) begin
            i_valid = 1'b1; i_binary_code = 4'(sent);
            i_ready = !(cyc >= 6 && cyc <= 10);
            #1;
            if (cyc == 6) begin
                held = o_gray_code;
                checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_at_stall: got %b expected 1", o_valid); end
            end
            if (cyc >= 7 && cyc <= 10) begin
                checks++;
                if (o_valid !== 1'b1 || o_gray_code !== held) begin
                    errors++; $display("FAIL bp_hold_cyc%0d: got v=%b g=%0d expected v=1 g=%0d", cyc, o_valid, o_gray_code, held);
                end
            end
            if (cyc == 10) begin
                checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", o_ready); end
            end
            acc = i_valid & o_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (PS + 2) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== gray_tab[i]) begin
                errors++; $display("FAIL bp_seq%0d: got %0d expected %0d", i, out_q[i], gray_tab[i]);
            end
        end
    endtask

    task automatic test_bubbles;
        int sent;
        int cyc;
        logic acc;
        out_q.delete(); sent = 0; cyc = 0;
        while (sent < 16 && cyc < 400) begin
            i_valid       = (cyc % 2 == 0);
            i_binary_code = 4'(15 - sent);
            i_ready       = 1'($urandom_range(0, 1));
            #1;
            acc = i_valid & o_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (PS + 2) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 16) begin errors++; $display("FAIL bub_count: got %0d expected 16", out_q.size()); end
        for (int i = 0; i < 16 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== gray_tab[15-i]) begin
                errors++; $display("FAIL bub_seq%0d: got %0d expected %0d", i, out_q[i], gray_tab[15-i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        i_ready = 1'b0; i_valid = 1'b1; i_binary_code = 4'd9;
        repeat (PS + 1) @(posedge clk);
        #1;
        checks++; if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL rm_full: got ready=%b busy=%b expected ready=0 busy=1", o_ready, o_busy);
        end
        rst_n = 1'b0; i_binary_code = 4'd3;
        @(posedge clk); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", o_valid); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", o_busy); end
        checks++; if (o_gray_code !== 4'd0) begin errors++; $display("FAIL rm_gray: got %0d expected 0", o_gray_code); end
        out_q.delete();
        rst_n = 1'b1; i_ready = 1'b1; i_valid = 1'b1; i_binary_code = 4'd5;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (PS + 3) @(posedge clk);
        #1;
        checks++; if (out_q.size() != 1) begin errors++; $display("FAIL rm_count: got %0d expected 1", out_q.size()); end
        if (out_q.size() > 0) begin
            checks++; if (out_q[0] !== 4'd7) begin errors++; $display("FAIL rm_b5: got %0d expected 7", out_q[0]); end
        end
    endtask

    task automatic test_round_trip;
        logic [7:0] val;
        rec4.delete(); rec64.delete(); rec256.delete(); rt_in.delete();
        rt_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            val      = 8'($urandom_range(0, 255));
            rt_valid = 1'($urandom_range(0, 1));
            d4 = val[1:0]; d64 = val[5:0]; d256 = val;
            if (rt_valid) rt_in.push_back(val);
            @(posedge clk); #1;
        end
        rt_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rec4.size() != rt_in.size() || rec64.size() != rt_in.size() || rec256.size() != rt_in.size()) begin
            errors++; $display("FAIL rt_count: got %0d/%0d/%0d expected %0d", rec4.size(), rec64.size(), rec256.size(), rt_in.size());
        end
        for (int i = 0; i < rt_in.size(); i++) begin
            val = rt_in[i];
            if (i < rec4.size()) begin
                checks++; if (rec4[i] !== {6'b0, val[1:0]}) begin errors++; $display("FAIL rt4_%0d: got %0d expected %0d", i, rec4[i], val[1:0]); end
            end
            if (i < rec64.size()) begin
                checks++; if (rec64[i] !== {2'b0, val[5:0]}) begin errors++; $display("FAIL rt64_%0d: got %0d expected %0d", i, rec64[i], val[5:0]); end
            end
            if (i < rec256.size()) begin
                checks++; if (rec256[i] !== val) begin errors++; $display("FAIL rt256_%0d: got %0d expected %0d", i, rec256[i], val); end
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_binary_code = '0;
        rt_valid = 1'b0; rt_ready = 1'b1; d4 = '0; d64 = '0; d256 = '0;
        @(posedge clk); #1;
        test_reset();
        test_map();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
